// File: rtl/capture_pkg.sv
// capture_pkg: shared definitions for the frame capture controller.
//   state_t   - capture FSM state encoding (also driven out on the debug port)
//   DROP_W    - width of the dropped-frame counter
//   calc_aw() - pixel address width for a given resolution
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    localparam int DROP_W = 8;

    function automatic int calc_aw(input int width, input int height);
        return $clog2(width * height);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers a level input and flags its edges.
// Ports:
//   i_clk, i_rst - clock, asynchronous active-high reset
//   i_sig        - level input (already in the i_clk domain)
//   o_rise       - high for the cycle in which i_sig is 1 and its registered copy is 0
//   o_fall       - high for the cycle in which i_sig is 0 and its registered copy is 1
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_sig;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sig <= 1'b0;
        end else begin
            r_sig <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig;
    assign o_fall = ~i_sig & r_sig;

endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: camera frame capture into video memory.
// A frame runs from a VSYNC fall to the next VSYNC rise. Pixels with DV
// are written one cycle later; a frame with exactly W*H writes is published
// to the display side, any other count raises a sticky error.
// Build option: FRAME_CAPTURE_PINGPONG_EN selects two-bank operation (write
// bank alternates, frames are dropped while the display still owns the
// published bank). Without it a single bank 0 is used.
// Ports:
//   PCLK, RST        - pixel clock, asynchronous active-high reset
//   VSYNC, DV        - frame sync (high = blank), pixel valid
//   i_w_addr, i_pixel- pixel address and data
//   i_start, i_stop  - arm / stop requests
//   i_continuous     - re-arm after each frame
//   i_rd_release     - display finished with the published bank
//   o_we/o_waddr/o_wdata - memory write port, o_waddr = {bank, address}
//   o_rd_bank        - bank holding the latest complete frame
//   o_frame_ready    - one-cycle publish pulse
//   o_busy           - FSM not idle
//   o_frame_err      - sticky short/long frame flag
//   o_drop_count     - saturating dropped-frame count
//   o_dbg_state      - current FSM state
module frame_capture_ctrl
    import capture_pkg::*;
#(
    parameter int RESOLUTION_WIDTH  = 640,
    parameter int RESOLUTION_HEIGHT = 480,
    localparam int AW = calc_aw(RESOLUTION_WIDTH, RESOLUTION_HEIGHT)
) (
    input  logic              PCLK,
    input  logic              RST,
    input  logic              VSYNC,
    input  logic              DV,
    input  logic [AW-1:0]     i_w_addr,
    input  logic [15:0]       i_pixel,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_continuous,
    input  logic              i_rd_release,
    output logic              o_we,
    output logic [AW:0]       o_waddr,
    output logic [15:0]       o_wdata,
    output logic              o_rd_bank,
    output logic              o_frame_ready,
    output logic              o_busy,
    output logic              o_frame_err,
    output logic [DROP_W-1:0] o_drop_count,
    output logic [1:0]        o_dbg_state
);

    localparam logic [AW:0] FRAME_PIXELS = (AW+1)'(RESOLUTION_WIDTH * RESOLUTION_HEIGHT);
    localparam logic [AW:0] CNT_ONE      = (AW+1)'(1);

    state_t      r_state;
    state_t      w_next_state;
    logic [AW:0] r_wcount;
    logic        r_stop;
    logic        w_rise;
    logic        w_fall;
    logic        w_wbank;
    logic        w_rd_pending;
    logic        w_drop;
    logic        w_publish_ok;
    logic        w_publish_bad;
    logic        w_enter_capture;

    sync_edge_detect u_vsync_edge (
        .i_clk  (PCLK),
        .i_rst  (RST),
        .i_sig  (VSYNC),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_drop        = 1'b0;
        w_publish_ok  = 1'b0;
        w_publish_bad = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // stop beats a simultaneous start
                if (i_start && !i_stop) w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (i_stop) begin
                    w_next_state = ST_IDLE;
                end else if (w_fall) begin
                    // display still owns the other bank: skip this frame
                    if (w_rd_pending) w_drop = 1'b1;
                    else              w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_rise) w_next_state = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                if (r_wcount == FRAME_PIXELS) w_publish_ok  = 1'b1;
                else                          w_publish_bad = 1'b1;
                if (i_continuous && !r_stop && !i_stop) w_next_state = ST_ARMED;
                else                                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_enter_capture = (r_state == ST_ARMED) && (w_next_state == ST_CAPTURE);

    // Write port and per-frame bookkeeping. The write counter tracks the
    // writes being issued, so in PUBLISH it already includes the last one.
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            o_we          <= 1'b0;
            o_waddr       <= '0;
            o_wdata       <= '0;
            o_frame_ready <= 1'b0;
            o_frame_err   <= 1'b0;
            o_drop_count  <= '0;
            r_wcount      <= '0;
            r_stop        <= 1'b0;
        end else begin
            o_we          <= (r_state == ST_CAPTURE) && DV;
            o_waddr       <= {w_wbank, i_w_addr};
            o_wdata       <= i_pixel;
            o_frame_ready <= w_publish_ok;
            if (w_publish_bad) o_frame_err <= 1'b1;
            if (w_drop && (o_drop_count != {DROP_W{1'b1}})) begin
                o_drop_count <= o_drop_count + 1'b1;
            end
            if (w_enter_capture) begin
                r_wcount <= '0;
            end else if ((r_state == ST_CAPTURE) && DV) begin
                r_wcount <= r_wcount + CNT_ONE;
            end
            if ((r_state == ST_CAPTURE) && i_stop) begin
                r_stop <= 1'b1;
            end else if (r_state == ST_PUBLISH) begin
                r_stop <= 1'b0;
            end
        end
    end

`ifdef FRAME_CAPTURE_PINGPONG_EN
    logic r_wbank;
    logic r_rd_pending;
    logic r_rd_bank;

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            r_wbank      <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_rd_pending <= 1'b0;
        end else begin
            if (w_publish_ok) begin
                r_rd_bank <= r_wbank;
                r_wbank   <= ~r_wbank;
            end
            // a publish in the same cycle as a release keeps the bank held
            if (w_publish_ok)      r_rd_pending <= 1'b1;
            else if (i_rd_release) r_rd_pending <= 1'b0;
        end
    end

    assign w_wbank      = r_wbank;
    assign w_rd_pending = r_rd_pending;
    assign o_rd_bank    = r_rd_bank;
`else
    logic w_unused_release;
    assign w_unused_release = i_rd_release;
    assign w_wbank          = 1'b0;
    assign w_rd_pending     = 1'b0;
    assign o_rd_bank        = 1'b0;
`endif

    assign o_busy      = (r_state != ST_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
module tb_frame_capture_ctrl;
    import capture_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;
`ifdef FRAME_CAPTURE_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic          PCLK;
    logic          RST;
    logic          VSYNC;
    logic          DV;
    logic [AW-1:0] i_w_addr;
    logic [15:0]   i_pixel;
    logic          i_start;
    logic          i_stop;
    logic          i_continuous;
    logic          i_rd_release;
    logic          o_we;
    logic [AW:0]   o_waddr;
    logic [15:0]   o_wdata;
    logic          o_rd_bank;
    logic          o_frame_ready;
    logic          o_busy;
    logic          o_frame_err;
    logic [7:0]    o_drop_count;
    logic [1:0]    o_dbg_state;

    frame_capture_ctrl #(
        .RESOLUTION_WIDTH  (W),
        .RESOLUTION_HEIGHT (H)
    ) dut (
        .PCLK          (PCLK),
        .RST           (RST),
        .VSYNC         (VSYNC),
        .DV            (DV),
        .i_w_addr      (i_w_addr),
        .i_pixel       (i_pixel),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_continuous  (i_continuous),
        .i_rd_release  (i_rd_release),
        .o_we          (o_we),
        .o_waddr       (o_waddr),
        .o_wdata       (o_wdata),
        .o_rd_bank     (o_rd_bank),
        .o_frame_ready (o_frame_ready),
        .o_busy        (o_busy),
        .o_frame_err   (o_frame_err),
        .o_drop_count  (o_drop_count),
        .o_dbg_state   (o_dbg_state)
    );

    // clock / reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // reference model: frame-level view of the controller
    bit       m_armed;
    bit       m_pending;
    bit       m_bank;
    bit       m_rd_bank;
    bit       m_err;
    int       m_drop;
    int       m_ready;
    int       ready_seen;
    logic [AW+16:0] exp_q[$];

    task automatic model_reset();
        m_armed   = 0;
        m_pending = 0;
        m_bank    = 0;
        m_rd_bank = 0;
        m_err     = 0;
        m_drop    = 0;
        exp_q.delete();
    endtask

    // scoreboard: every memory write must match the next expected one
    always @(negedge PCLK) begin
        if (!RST) begin
            if (o_frame_ready) ready_seen++;
            if (o_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", {28'd0, o_waddr}, 32'hffff_ffff);
                end else begin
                    check("write", {12'd0, o_waddr, o_wdata}, {12'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // driver tasks (inputs change 1 ns after the rising edge)
    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic start(input bit with_stop);
        i_start = 1'b1;
        i_stop  = with_stop;
        step(1);
        i_start = 1'b0;
        i_stop  = 1'b0;
        if (with_stop)     m_armed = 0;
        else if (!m_armed) m_armed = 1;
    endtask

    task automatic stop_pulse();
        i_stop = 1'b1;
        step(1);
        i_stop = 1'b0;
        m_armed = 0;
    endtask

    task automatic release_pulse();
        i_rd_release = 1'b1;
        step(1);
        i_rd_release = 1'b0;
        if (PP) m_pending = 0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_busy"},   {31'd0, o_busy}, {31'd0, m_armed});
        check({tag, "_state"},  {30'd0, o_dbg_state}, m_armed ? 32'(ST_ARMED) : 32'(ST_IDLE));
        check({tag, "_ready"},  ready_seen, m_ready);
        check({tag, "_rdbank"}, {31'd0, o_rd_bank}, {31'd0, m_rd_bank});
        check({tag, "_err"},    {31'd0, o_frame_err}, {31'd0, m_err});
        check({tag, "_drop"},   {24'd0, o_drop_count}, m_drop);
        check({tag, "_wrleft"}, exp_q.size(), 0);
    endtask

    // one VSYNC-low period carrying n_dv pixels
    task automatic run_frame(input string tag, input int n_dv, input bit stop_mid,
                             input bit rel_pub, input bit rel_after);
        bit          cap;
        bit          dropped;
        logic [AW-1:0] addr;
        logic [15:0] pix;
        cap     = m_armed && !(PP && m_pending);
        dropped = m_armed && PP && m_pending;
        if (dropped && m_drop < 255) m_drop++;
        VSYNC = 1'b0;
        step(2);
        for (int i = 0; i < n_dv; i++) begin
            step($urandom_range(0, 2));
            addr     = AW'($urandom_range(0, W*H-1));
            pix      = 16'($urandom);
            DV       = 1'b1;
            i_w_addr = addr;
            i_pixel  = pix;
            if (stop_mid && i == n_dv/2) i_stop = 1'b1;
            if (cap) exp_q.push_back({m_bank, addr, pix});
            step(1);
            DV     = 1'b0;
            i_stop = 1'b0;
        end
        step(1);
        VSYNC = 1'b1;
        step(1);
        // a captured frame is now in its publish cycle
        if (rel_pub) i_rd_release = 1'b1;
        step(1);
        i_rd_release = 1'b0;
        if (cap) begin
            if (n_dv == W*H) begin
                m_ready++;
                m_rd_bank = m_bank;
                if (PP) begin
                    m_bank    = ~m_bank;
                    m_pending = 1;
                end
            end else begin
                m_err = 1;
                if (rel_pub && PP) m_pending = 0;
            end
            m_armed = i_continuous && !stop_mid;
        end else begin
            if (rel_pub && PP) m_pending = 0;
            m_armed = m_armed && !stop_mid;
        end
        step(2);
        if (rel_after) release_pulse();
        step(2);
        check_status(tag);
    endtask

    initial begin
        RST          = 1'b1;
        VSYNC        = 1'b1;
        DV           = 1'b0;
        i_w_addr     = '0;
        i_pixel      = '0;
        i_start      = 1'b0;
        i_stop       = 1'b0;
        i_continuous = 1'b0;
        i_rd_release = 1'b0;
        ready_seen   = 0;
        m_ready      = 0;
        model_reset();
        step(3);
        check("rst_we",     {31'd0, o_we}, 0);
        check("rst_waddr",  {28'd0, o_waddr}, 0);
        check("rst_wdata",  {16'd0, o_wdata}, 0);
        check("rst_busy",   {31'd0, o_busy}, 0);
        check("rst_rdbank", {31'd0, o_rd_bank}, 0);
        check("rst_err",    {31'd0, o_frame_err}, 0);
        check("rst_drop",   {24'd0, o_drop_count}, 0);
        RST = 1'b0;
        step(2);
        check_status("idle");

        // single shot
        i_continuous = 1'b0;
        start(0);
        check("armed_busy", {31'd0, o_busy}, 1);
        run_frame("single", W*H, 0, 0, 1);

        // continuous with release between frames
        i_continuous = 1'b1;
        start(0);
        run_frame("cont1", W*H, 0, 0, 1);
        run_frame("cont2", W*H, 0, 0, 0);

        // no release: next frame dropped, then recover
        run_frame("drop", W*H, 0, 0, 0);
        release_pulse();
        run_frame("after_drop", W*H, 0, 0, 1);

        // short frame
        run_frame("short", W*H-1, 0, 0, 1);
        stop_pulse();
        check_status("stop_armed");

        // stop during capture
        i_continuous = 1'b1;
        start(0);
        run_frame("stop_mid", W*H, 1, 0, 1);

        // publish and release in the same cycle: publish wins
        start(0);
        run_frame("pub_rel", W*H, 0, 1, 0);
        run_frame("pub_rel_next", W*H, 0, 0, 0);
        stop_pulse();
        release_pulse();

        // start together with stop while idle
        start(1);
        step(2);
        check_status("start_stop");

        // reset in the middle of a capture
        i_continuous = 1'b0;
        start(0);
        VSYNC = 1'b0;
        step(2);
        for (int i = 0; i < 3; i++) begin
            DV       = 1'b1;
            i_w_addr = AW'(i);
            i_pixel  = 16'($urandom);
            exp_q.push_back({m_bank, AW'(i), i_pixel});
            step(1);
        end
        #2;
        check("we_before_rst", {31'd0, o_we}, 1);
        RST = 1'b1;
        #1;
        check("mrst_we",     {31'd0, o_we}, 0);
        check("mrst_waddr",  {28'd0, o_waddr}, 0);
        check("mrst_wdata",  {16'd0, o_wdata}, 0);
        check("mrst_ready",  {31'd0, o_frame_ready}, 0);
        check("mrst_rdbank", {31'd0, o_rd_bank}, 0);
        check("mrst_busy",   {31'd0, o_busy}, 0);
        check("mrst_err",    {31'd0, o_frame_err}, 0);
        check("mrst_drop",   {24'd0, o_drop_count}, 0);
        DV    = 1'b0;
        VSYNC = 1'b1;
        model_reset();
        step(2);
        RST = 1'b0;
        step(2);
        check_status("post_rst");
        start(0);
        run_frame("post_rst_frame", W*H, 0, 0, 0);

        // randomized frame sequence
        for (int it = 0; it < 24; it++) begin
            int r;
            if (!m_armed && $urandom_range(0, 3) != 0) begin
                i_continuous = 1'($urandom_range(0, 1));
                start(0);
            end
            r = $urandom_range(0, 4);
            run_frame("rand", (r == 0) ? W*H-1 : (r == 4) ? W*H+1 : W*H,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                      1'($urandom_range(0, 1)));
        end

        step(4);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
